fb_read_sched: RTL
==================

Name: fb_read_sched

Overview:
- Frame-buffer read scheduler between the DDR user read interface and the display line FIFO.
- The display timing block pops 256-bit words from the FIFO during active video.
- This block issues fixed-length DDR read bursts for each frame, writes the returned words into the FIFO, and keeps the FIFO from overflowing through credit accounting.
- It restarts the frame on each vsync rising edge.

Parameters:
- ADDR_W, 28, DDR command address width.
- ADDR_PER_WORD, 8, address increment per 256-bit word.
- H_WORDS, 64, 256-bit words per line (1024 px x RGB565).
- V_LINES, 768, lines per frame.
- BURST_LEN, 16, words per read command; H_WORDS*V_LINES must be a multiple of it.
- FIFO_DEPTH, 512, line FIFO depth in words.
- LVL_W, 10, width of the fifo_level input.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- nrst  in  1  synchronous active-low reset.
- ddr_init_done  in  1  DDR calibration complete.
- vs_in  in  1  vsync from the display timing block, same clock domain.
- frame_base  in  ADDR_W  frame start address; sampled on the vs rising edge.
- cmd_en  out  1  read command valid.
- cmd_ready  in  1  DDR accepts the command when cmd_en && cmd_ready.
- cmd_addr  out  ADDR_W  burst start address.
- cmd_len  out  8  burst length, constant BURST_LEN.
- rd_valid  in  1  DDR read data valid.
- rd_data  in  256  DDR read data.
- fifo_level  in  LVL_W  current FIFO word count.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wdata  out  256  FIFO write data.
- fifo_clr  out  1  FIFO synchronous clear.
- frame_done  out  1  one-cycle pulse when the last word of a frame is written.
- err_unexp  out  1  sticky; set on rd_valid while outstanding==0.

Behaviour:
- Reset: every output is 0. State IDLE. outstanding=0, burst_cnt=0, base register=0.
- States:
  - IDLE: wait for ddr_init_done=1, then go to WAIT_VS.
  - WAIT_VS: wait for a vs rising edge (vs_d0=0 and vs_in=1).
  - FLUSH: drain in-flight data and clear the FIFO.
  - FILL: issue bursts for the current frame.
  - DONE: all bursts for the frame have been issued.
- Any state except IDLE: a vs rising edge latches frame_base and requests FLUSH.
  - If a command is pending (cmd_en=1, not yet accepted), cmd_en stays high and cmd_addr stays stable until the handshake completes.
  - FLUSH is entered on the cycle after acceptance.
  - cmd_en must never drop without a handshake.
- FLUSH:
  - fifo_clr=1 for every cycle in FLUSH.
  - rd_valid data is discarded (fifo_wr_en=0) but still decrements outstanding.
  - Exit to FILL when outstanding==0 and at least one FLUSH cycle has elapsed. On exit, burst_cnt=0 and addr=latched base.
- FILL issue rule: assert cmd_en when fifo_level + outstanding + BURST_LEN <= FIFO_DEPTH and burst_cnt < H_WORDS*V_LINES/BURST_LEN.
  - Compute the sum at LVL_W+2 bits; no wrap.
  - On handshake: outstanding += BURST_LEN, addr += BURST_LEN*ADDR_PER_WORD (modulo 2^ADDR_W, wraps silently), burst_cnt += 1.
  - cmd_en deasserts on the cycle after a handshake unless the issue rule holds again; back-to-back handshakes are allowed.
- When the last burst is accepted, go to DONE.
  - DONE keeps forwarding returned data.
  - DONE moves to FLUSH on the next vs rising edge.
- Data path (FILL and DONE):
  - rd_valid: fifo_wr_en=1 and fifo_wdata=rd_data one cycle later (registered, latency 1).
  - outstanding -= 1.
  - Simultaneous handshake and rd_valid: outstanding += BURST_LEN-1.
- rd_valid while outstanding==0 in any state: data dropped, err_unexp<=1, outstanding stays 0. err_unexp clears only on reset.
- frame_done pulses together with the fifo_wr_en of word H_WORDS*V_LINES of the frame. It does not pulse for an aborted frame.
- ddr_init_done falling in any state: return to IDLE and drop cmd_en immediately. This is a DDR re-init, and the handshake rule is waived. outstanding is cleared to 0.
- nrst low mid-burst: all state returns to reset values on the next clk edge; any in-flight data is ignored.

Test Plan:
- Bench params H_WORDS=4, V_LINES=2, BURST_LEN=4, FIFO_DEPTH=16, frame_base=0x100, ADDR_PER_WORD=8, cmd_ready tied 1, DDR model returns data 5 cycles after accept. Pulse vs -> fifo_clr 1+ cycles, then commands at addr 0x100 and 0x120, 8 FIFO writes in order, frame_done on the 8th write, state DONE.
- Same bench, fifo_level held at 10 -> exactly one command issued (10+0+4<=16, 10+4+4>16). Release fifo_level to 0 after data returns -> second command issued.
- cmd_ready low for 20 cycles with cmd_en high and vs rising mid-wait -> cmd_en and cmd_addr stable until ready; FLUSH entered the cycle after accept; 4 returned words dropped; FILL restarts at the new frame_base.
- Same cycle as a handshake, rd_valid=1 with outstanding=4 -> outstanding=7.
- rd_valid asserted in WAIT_VS -> no FIFO write, err_unexp=1, held through a following frame.
- ddr_init_done deasserted during FILL with outstanding=8 -> cmd_en=0 next cycle, state IDLE, outstanding=0. After re-assert, waits for vs before issuing.

Source files
------------

// File: rtl/fb_read_sched.sv
// Frame-buffer read scheduler: issues fixed-length DDR read bursts per frame,
// forwards returned words into the display line FIFO under credit control.
module fb_read_sched #(
    parameter int ADDR_W        = 28,
    parameter int ADDR_PER_WORD = 8,
    parameter int H_WORDS       = 64,
    parameter int V_LINES       = 768,
    parameter int BURST_LEN     = 16,
    parameter int FIFO_DEPTH    = 512,
    parameter int LVL_W         = 10
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ddr_init_done,
    input  logic              vs_in,
    input  logic [ADDR_W-1:0] frame_base,
    output logic              cmd_en,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    input  logic              rd_valid,
    input  logic [255:0]      rd_data,
    input  logic [LVL_W-1:0]  fifo_level,
    output logic              fifo_wr_en,
    output logic [255:0]      fifo_wdata,
    output logic              fifo_clr,
    output logic              frame_done,
    output logic              err_unexp
);

    localparam int TOTAL_WORDS  = H_WORDS * V_LINES;
    localparam int TOTAL_BURSTS = TOTAL_WORDS / BURST_LEN;
    localparam int BCNT_W       = $clog2(TOTAL_BURSTS + 1);
    localparam int WCNT_W       = $clog2(TOTAL_WORDS + 1);
    localparam int OUT_W        = LVL_W + 1;
    localparam int SUM_W        = LVL_W + 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_VS = 3'd1,
        FLUSH   = 3'd2,
        FILL    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t             state, state_nx;
    logic               vs_d0;
    logic [ADDR_W-1:0]  base_q, base_nx;
    logic [ADDR_W-1:0]  addr_q, addr_nx;
    logic [BCNT_W-1:0]  burst_cnt, burst_cnt_nx;
    logic [WCNT_W-1:0]  word_cnt, word_cnt_nx;
    logic [OUT_W-1:0]   outstanding, out_nx;
    logic               cmd_en_q, cmd_en_nx;
    logic               flush_req, flush_req_nx;
    logic               wr_en_q, wr_en_nx;
    logic [255:0]       wdata_q;
    logic               frame_done_q, frame_done_nx;
    logic               err_q, err_nx;
    logic [SUM_W-1:0]   credit_sum;

    logic hs, pending, vs_rise, rd_ok, rd_unexp, forward;

    assign hs       = cmd_en_q & cmd_ready;
    assign pending  = cmd_en_q & ~cmd_ready;
    assign vs_rise  = vs_in & ~vs_d0;
    assign rd_ok    = rd_valid && (outstanding != '0);
    assign rd_unexp = rd_valid && (outstanding == '0);
    assign forward  = rd_ok && ((state == FILL) || (state == DONE));

    // Next-state, credit accounting and command issue decision.
    always_comb begin
        state_nx      = state;
        base_nx       = base_q;
        addr_nx       = addr_q;
        burst_cnt_nx  = burst_cnt;
        word_cnt_nx   = word_cnt;
        out_nx        = outstanding;
        flush_req_nx  = flush_req;
        wr_en_nx      = forward;
        frame_done_nx = 1'b0;
        err_nx        = err_q | rd_unexp;
        cmd_en_nx     = 1'b0;
        credit_sum    = '0;

        if (hs) begin
            out_nx       = out_nx + OUT_W'(BURST_LEN);
            addr_nx      = addr_q + ADDR_W'(BURST_LEN * ADDR_PER_WORD);
            burst_cnt_nx = burst_cnt + 1'b1;
        end
        if (rd_ok) begin
            out_nx = out_nx - 1'b1;
        end
        if (forward) begin
            word_cnt_nx = word_cnt + 1'b1;
            if (word_cnt_nx == WCNT_W'(TOTAL_WORDS)) begin
                frame_done_nx = 1'b1;
            end
        end
        if ((state != IDLE) && vs_rise) begin
            base_nx      = frame_base;
            flush_req_nx = 1'b1;
        end

        // A restart waits for any pending command to be accepted first.
        unique case (state)
            IDLE: begin
                if (ddr_init_done) begin
                    state_nx = WAIT_VS;
                end
            end
            WAIT_VS, FILL, DONE: begin
                if (flush_req_nx && !pending) begin
                    state_nx     = FLUSH;
                    flush_req_nx = 1'b0;
                end else if ((state == FILL) && hs &&
                             (burst_cnt_nx == BCNT_W'(TOTAL_BURSTS))) begin
                    state_nx = DONE;
                end
            end
            FLUSH: begin
                flush_req_nx = 1'b0;
                if (out_nx == '0) begin
                    state_nx     = FILL;
                    addr_nx      = base_nx;
                    burst_cnt_nx = '0;
                    word_cnt_nx  = '0;
                end
            end
            default: state_nx = IDLE;
        endcase

        credit_sum = SUM_W'(fifo_level) + SUM_W'(out_nx) + SUM_W'(BURST_LEN);
        if (pending) begin
            cmd_en_nx = 1'b1;
        end else if ((state_nx == FILL) && !flush_req_nx &&
                     (credit_sum <= SUM_W'(FIFO_DEPTH)) &&
                     (burst_cnt_nx < BCNT_W'(TOTAL_BURSTS))) begin
            cmd_en_nx = 1'b1;
        end

        // DDR re-initialisation abandons everything, including a pending command.
        if (!ddr_init_done) begin
            state_nx     = IDLE;
            cmd_en_nx    = 1'b0;
            out_nx       = '0;
            flush_req_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state        <= IDLE;
            vs_d0        <= 1'b0;
            base_q       <= '0;
            addr_q       <= '0;
            burst_cnt    <= '0;
            word_cnt     <= '0;
            outstanding  <= '0;
            cmd_en_q     <= 1'b0;
            flush_req    <= 1'b0;
            wr_en_q      <= 1'b0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_nx;
            vs_d0        <= vs_in;
            base_q       <= base_nx;
            addr_q       <= addr_nx;
            burst_cnt    <= burst_cnt_nx;
            word_cnt     <= word_cnt_nx;
            outstanding  <= out_nx;
            cmd_en_q     <= cmd_en_nx;
            flush_req    <= flush_req_nx;
            wr_en_q      <= wr_en_nx;
            frame_done_q <= frame_done_nx;
            err_q        <= err_nx;
            if (forward) begin
                wdata_q <= rd_data;
            end
        end
    end

    assign cmd_en     = cmd_en_q;
    assign cmd_addr   = addr_q;
    assign cmd_len    = 8'(BURST_LEN);
    assign fifo_wr_en = wr_en_q;
    assign fifo_wdata = wdata_q;
    assign fifo_clr   = (state == FLUSH);
    assign frame_done = frame_done_q;
    assign err_unexp  = err_q;

endmodule
